// File: rtl/thresh_pack_ctrl.sv
// thresh_pack_ctrl: binarises one full frame read from a sync-read image RAM and
// packs 8 results per byte (LSB first) into an output RAM.
// Latency: done pulses N+3 cycles after the accepted start; one pixel per clock.
// Backpressure: none; the RAMs must accept one read and at most one write per cycle.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start, threshold  start request (taken only in IDLE) and threshold latched with it
//   busy, done        pass in progress / one-cycle end-of-pass pulse
//   rd_en, rd_addr    image RAM read strobe and pixel index (data returns next cycle)
//   rd_data           pixel value for the read issued on the previous cycle
//   wr_en, wr_addr,   packed-byte write strobe, byte index and data
//   wr_data
//   fg_count          foreground pixel count of the last/current pass
//
// Build option: define THRESH_PACK_INVERT_EN to treat dark pixels (below threshold)
// as foreground. Timing and ports are identical in both builds.
module thresh_pack_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 8,
  localparam int N    = IMG_W * IMG_H,
  localparam int NB   = (N + 7) / 8,
  localparam int PA_W = $clog2(N),
  localparam int BA_W = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PIX_W-1:0] threshold,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [PA_W-1:0]  rd_addr,
  input  logic [PIX_W-1:0] rd_data,
  output logic             wr_en,
  output logic [BA_W-1:0]  wr_addr,
  output logic [7:0]       wr_data,
  output logic [PA_W:0]    fg_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  localparam logic [PA_W-1:0] LAST = PA_W'(N - 1);

  state_t            state_q, state_d;
  logic [PA_W-1:0]   pix_cnt_q;   // next pixel index to read
  logic [PIX_W-1:0]  thr_q;
  logic              cap_vld_q;   // rd_data carries pixel cap_idx_q this cycle
  logic [PA_W-1:0]   cap_idx_q;
  logic [7:0]        buf_q;
  logic              wr_en_q;
  logic [BA_W-1:0]   wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              done_q;
  logic [PA_W:0]     fg_q;

  logic              pix_bit;
  logic [31:0]       cap_idx_w;   // widened so bit-slicing works for any PA_W
  logic [7:0]        byte_nxt;
  logic              byte_end;
  logic              start_acc;

  always_comb begin
`ifdef THRESH_PACK_INVERT_EN
    pix_bit = (rd_data < thr_q);
`else
    pix_bit = (rd_data >= thr_q);
`endif
    cap_idx_w = 32'(cap_idx_q);
    byte_nxt  = buf_q | (8'(pix_bit) << cap_idx_w[2:0]);
    // A byte closes on its 8th pixel or on the last pixel of the frame.
    byte_end  = cap_vld_q && ((cap_idx_w[2:0] == 3'd7) || (cap_idx_q == LAST));
    start_acc = (state_q == IDLE) && start;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (pix_cnt_q == LAST) state_d = DRAIN;
      DRAIN:   if (cap_vld_q && (cap_idx_q == LAST)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt_q <= '0;
      thr_q     <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      buf_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      fg_q      <= '0;
    end else begin
      wr_en_q   <= 1'b0;
      // done lands in the cycle after FIN, together with the return to IDLE.
      done_q    <= (state_q == FIN);
      cap_vld_q <= (state_q == RUN);
      cap_idx_q <= pix_cnt_q;

      if (start_acc) begin
        thr_q     <= threshold;
        fg_q      <= '0;
        pix_cnt_q <= '0;
        buf_q     <= '0;
      end

      if ((state_q == RUN) && (pix_cnt_q != LAST)) begin
        pix_cnt_q <= pix_cnt_q + 1'b1;
      end

      if (cap_vld_q) begin
        fg_q <= fg_q + (PA_W+1)'(pix_bit);
        if (byte_end) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= BA_W'(cap_idx_w >> 3);
          wr_data_q <= byte_nxt;
          buf_q     <= '0;
        end else begin
          buf_q <= byte_nxt;
        end
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign rd_en    = (state_q == RUN);
  assign rd_addr  = rd_en ? pix_cnt_q : '0;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = done_q;
  assign fg_count = fg_q;

endmodule

// File: tb/tb_thresh_pack_ctrl.sv
// tb_thresh_pack_ctrl: randomized and directed frame passes on a 5x2 image, checked
// cycle by cycle against a reference model built from the thresholding rules.
// Latency/backpressure: n/a (bench).
module tb_thresh_pack_ctrl;

  localparam int W    = 5;
  localparam int H    = 2;
  localparam int N    = W * H;
  localparam int NB   = (N + 7) / 8;
  localparam int PA_W = $clog2(N);
  localparam int BA_W = (NB > 1) ? $clog2(NB) : 1;
`ifdef THRESH_PACK_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [7:0]       threshold;
  logic             busy, done, rd_en, wr_en;
  logic [PA_W-1:0]  rd_addr;
  logic [7:0]       rd_data = 8'd0;
  logic [BA_W-1:0]  wr_addr;
  logic [7:0]       wr_data;
  logic [PA_W:0]    fg_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] img [N];
  logic [7:0] got [NB];
  int         got_n;

  always #5 clk = ~clk;

  thresh_pack_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .threshold(threshold),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fg_count(fg_count)
  );

  // Synchronous-read image RAM.
  always @(posedge clk) begin
    if (rd_en && (int'(rd_addr) < N)) rd_data <= img[rd_addr];
  end

  task automatic check(input string tag, input int got_v, input int exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               tag, got_v, got_v, exp_v, exp_v, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_fg"}, fg_count, 0);
  endtask

  // One full pass; cycle rel is the rel-th cycle after the start edge.
  task automatic run_pass(input logic [7:0] thr, input bit disturb, output int fg_seen);
    int         fg_e;
    logic [7:0] eb [NB];
    int         wcyc [NB];
    int         exp_wr, exp_b, last;
    bit         b;

    fg_e = 0;
    for (int i = 0; i < NB; i++) begin
      eb[i] = 8'd0;
      got[i] = 8'd0;
      last = (8 * i + 7 < N - 1) ? 8 * i + 7 : N - 1;
      wcyc[i] = last + 3;   // read at last+1, captured at last+2, written at last+3
    end
    for (int k = 0; k < N; k++) begin
      b = INV ? (img[k] < thr) : (img[k] >= thr);
      eb[k / 8] = eb[k / 8] | (8'(b) << (k % 8));
      fg_e += int'(b);
    end

    @(negedge clk);
    start = 1'b1;
    threshold = thr;
    @(negedge clk);
    start = 1'b0;
    threshold = 8'($urandom);
    got_n = 0;
    for (int rel = 1; rel <= N + 5; rel++) begin
      check("busy", busy, int'(rel <= N + 2));
      check("rd_en", rd_en, int'(rel <= N));
      if (rel <= N) check("rd_addr", rd_addr, rel - 1);
      exp_wr = 0;
      exp_b = 0;
      for (int i = 0; i < NB; i++) begin
        if (wcyc[i] == rel) begin
          exp_wr = 1;
          exp_b = i;
        end
      end
      check("wr_en", wr_en, exp_wr);
      if (wr_en && exp_wr == 1) begin
        check("wr_addr", wr_addr, exp_b);
        check("wr_data", wr_data, eb[exp_b]);
        got[exp_b] = wr_data;
      end
      if (wr_en) got_n++;
      check("done", done, int'(rel == N + 3));
      if (rel == N + 3) check("fg_count", fg_count, fg_e);
      if (disturb && rel == 3) begin
        start = 1'b1;
        threshold = ~thr;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("wr_count", got_n, NB);
    check("fg_hold", fg_count, fg_e);
    fg_seen = int'(fg_count);
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int k = 0; k < N; k++) img[k] = 8'($urandom_range(hi, lo));
  endtask

  int fg;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    threshold = 8'd0;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    reset = 1'b0;

    // Directed frame: first byte from the reference pixel sequence.
    img[0] = 8'd0;   img[1] = 8'd200; img[2] = 8'd128; img[3] = 8'd127;
    img[4] = 8'd255; img[5] = 8'd10;  img[6] = 8'd130; img[7] = 8'd90;
    img[8] = 8'd5;   img[9] = 8'd250;
    run_pass(8'd128, 1'b0, fg);
    check("dir_b0", got[0], INV ? 'hA9 : 'h56);
    check("dir_b1", got[1], INV ? 'h01 : 'h02);
    check("dir_fg", fg, 5);

    // Uniform frame giving a full byte then a 2-bit partial byte.
    for (int k = 0; k < N; k++) img[k] = 8'd150;
    run_pass(8'd100, 1'b0, fg);
    check("flat_b0", got[0], INV ? 'h00 : 'hFF);
    check("flat_b1", got[1], INV ? 'h00 : 'h03);
    check("flat_fg", fg, INV ? 0 : 10);

    // Threshold extremes.
    fill_random(0, 255);
    run_pass(8'd0, 1'b0, fg);
    check("thr0_fg", fg, INV ? 0 : 10);
    fill_random(0, 254);
    run_pass(8'd255, 1'b0, fg);
    check("thr255_fg", fg, INV ? 10 : 0);

    // Start and threshold change during a pass must be ignored.
    fill_random(0, 255);
    run_pass(8'd50, 1'b1, fg);

    // Reset in the cycle after the 3rd read.
    @(negedge clk);
    start = 1'b1;
    threshold = 8'($urandom);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rd_en3", rd_en, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("midrst");
    for (int i = 0; i < 15; i++) begin
      check("midrst_no_wr", wr_en, 0);
      check("midrst_no_busy", busy, 0);
      @(negedge clk);
    end
    fill_random(0, 255);
    run_pass(8'($urandom), 1'b0, fg);

    // start together with reset: reset wins.
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    threshold = 8'd7;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rst_start_busy", busy, 0);
      check("rst_start_rd", rd_en, 0);
      @(negedge clk);
    end

    // Randomized back-to-back passes.
    for (int p = 0; p < 8; p++) begin
      fill_random(0, 255);
      run_pass(8'($urandom), p[0], fg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
